hls_exec_monitor: RTL and testbench

//  Synthesizable run-time profiler for one HLS-generated block: tracks the block-level ap_ctrl handshake
//  (transaction count, latency, start interval) and one loop inside it (invocations, iterations, trip

---
 rtl/hls_mon_pkg.sv | 17 +
 rtl/hls_loop_tracker.sv | 79 +++++++
 rtl/hls_exec_monitor.sv | 124 ++++++++++++
 tb/tb_hls_exec_monitor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/hls_mon_pkg.sv
// Shared types and saturating-increment helper for the HLS execution monitor.
package hls_mon_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mod_state_e;
  typedef enum logic {L_IDLE = 1'b0, L_ACTIVE = 1'b1} loop_state_e;

  localparam int unsigned SAT_MAX_W = 64;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                   input int unsigned w);
    logic [SAT_MAX_W-1:0] top;
    top = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
    return (v >= top) ? v : v + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/hls_loop_tracker.sv
// Loop profiler: invocation FSM plus iteration, trip-count and stall counters.
module hls_loop_tracker #(
  parameter int STATE_W = 85,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               loop_start,
  input  logic               loop_done,
  output logic               loop_active,
  output logic [CNT_W-1:0]   loop_invoc_cnt,
  output logic [CNT_W-1:0]   loop_iter_cnt,
  output logic [CNT_W-1:0]   loop_last_trip,
  output logic [CNT_W-1:0]   loop_stall_cnt
);
  import hls_mon_pkg::*;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(SAT_MAX_W'(v), CNT_W));
  endfunction

  loop_state_e st, st_nxt;
  logic match_s, match_e, end_ev, stall_ev, invoc_ev, done_ev;

  assign match_s     = (cur_state == iter_start_state);
  assign match_e     = (cur_state == iter_end_state);
  assign loop_active = (st == L_ACTIVE);
  assign end_ev      = loop_active & match_e & iter_end_enable & ~iter_end_block;
  // A cycle stalled in both states is still one stall cycle.
  assign stall_ev    = loop_active & ((match_s & iter_start_enable & iter_start_block) |
                                      (match_e & iter_end_enable & iter_end_block));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) st <= L_IDLE;
    else if (en) st <= st_nxt;
  end

  always_comb begin
    st_nxt   = st;
    invoc_ev = 1'b0;
    done_ev  = 1'b0;
    case (st)
      L_IDLE: if (loop_start) begin
        invoc_ev = 1'b1;
        st_nxt   = L_ACTIVE;
      end
      L_ACTIVE: if (loop_done) begin
        done_ev = 1'b1;
        if (loop_start) invoc_ev = 1'b1;
        else st_nxt = L_IDLE;
      end
      default: st_nxt = L_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      loop_invoc_cnt <= '0;
      loop_iter_cnt  <= '0;
      loop_last_trip <= '0;
      loop_stall_cnt <= '0;
    end else if (en) begin
      if (invoc_ev) loop_invoc_cnt <= inc(loop_invoc_cnt);
      if (done_ev) loop_last_trip <= end_ev ? inc(loop_iter_cnt) : loop_iter_cnt;
      if (invoc_ev) loop_iter_cnt <= '0;
      else if (end_ev) loop_iter_cnt <= inc(loop_iter_cnt);
      if (stall_ev) loop_stall_cnt <= inc(loop_stall_cnt);
    end
  end

endmodule

// File: rtl/hls_exec_monitor.sv
// Run-time profiler for an HLS block: ap_ctrl transaction stats plus one loop tracker.
module hls_exec_monitor #(
  parameter int STATE_W = 85,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               loop_start,
  input  logic               loop_done,
  output logic               mod_busy,
  output logic [CNT_W-1:0]   mod_txn_cnt,
  output logic [CNT_W-1:0]   mod_last_lat,
  output logic [CNT_W-1:0]   mod_last_ii,
  output logic               loop_active,
  output logic [CNT_W-1:0]   loop_invoc_cnt,
  output logic [CNT_W-1:0]   loop_iter_cnt,
  output logic [CNT_W-1:0]   loop_last_trip,
  output logic [CNT_W-1:0]   loop_stall_cnt,
  output logic               frozen
);
  import hls_mon_pkg::*;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(SAT_MAX_W'(v), CNT_W));
  endfunction

  mod_state_e st, st_nxt;
  logic start_acc, done_acc, en, has_start;
  logic [CNT_W-1:0] lat_run, ii_run;
  logic unused_ap_ready;

  assign unused_ap_ready = ap_ready;
  // Freeze takes effect on the finish cycle itself.
  assign en       = ~frozen & ~finish;
  assign mod_busy = (st == RUN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st     <= IDLE;
      frozen <= 1'b0;
    end else begin
      if (en) st <= st_nxt;
      if (finish) frozen <= 1'b1;
    end
  end

  always_comb begin
    st_nxt    = st;
    start_acc = 1'b0;
    done_acc  = 1'b0;
    case (st)
      IDLE: if (ap_start) begin
        start_acc = 1'b1;
        if (ap_done & ap_continue) done_acc = 1'b1;
        else st_nxt = RUN;
      end
      RUN: if (ap_done & ap_continue) begin
        done_acc = 1'b1;
        if (ap_start) start_acc = 1'b1;
        else st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // lat_run/ii_run hold the distance from the last accepted start to the current cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mod_txn_cnt  <= '0;
      mod_last_lat <= '0;
      mod_last_ii  <= '0;
      lat_run      <= '0;
      ii_run       <= '0;
      has_start    <= 1'b0;
    end else if (en) begin
      if (done_acc) begin
        mod_txn_cnt  <= inc(mod_txn_cnt);
        mod_last_lat <= (st == IDLE) ? '0 : lat_run;
      end
      if (start_acc) lat_run <= CNT_W'(1);
      else if (st == RUN) lat_run <= inc(lat_run);
      if (start_acc) begin
        if (has_start) mod_last_ii <= ii_run;
        ii_run    <= CNT_W'(1);
        has_start <= 1'b1;
      end else if (has_start) begin
        ii_run <= inc(ii_run);
      end
    end
  end

  hls_loop_tracker #(.STATE_W(STATE_W), .CNT_W(CNT_W)) u_loop (
    .clock            (clock),
    .reset            (reset),
    .en               (en),
    .cur_state        (cur_state),
    .iter_start_state (iter_start_state),
    .iter_end_state   (iter_end_state),
    .iter_start_block (iter_start_block),
    .iter_end_block   (iter_end_block),
    .iter_start_enable(iter_start_enable),
    .iter_end_enable  (iter_end_enable),
    .loop_start       (loop_start),
    .loop_done        (loop_done),
    .loop_active      (loop_active),
    .loop_invoc_cnt   (loop_invoc_cnt),
    .loop_iter_cnt    (loop_iter_cnt),
    .loop_last_trip   (loop_last_trip),
    .loop_stall_cnt   (loop_stall_cnt)
  );

endmodule

// File: tb/tb_hls_exec_monitor.sv
// Directed bench for hls_exec_monitor: handshake timing, loop counters, freeze and reset.
module tb_hls_exec_monitor;
  localparam int STATE_W = 85;
  localparam int CNT_W   = 32;

  logic clock = 1'b0;
  logic reset, finish, ap_start, ap_ready, ap_done, ap_continue;
  logic [STATE_W-1:0] cur_state, iter_start_state, iter_end_state;
  logic iter_start_block, iter_end_block, iter_start_enable, iter_end_enable;
  logic loop_start, loop_done;
  logic mod_busy, loop_active, frozen;
  logic [CNT_W-1:0] mod_txn_cnt, mod_last_lat, mod_last_ii;
  logic [CNT_W-1:0] loop_invoc_cnt, loop_iter_cnt, loop_last_trip, loop_stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [STATE_W-1:0] st_idle, st_a, st_b, st_p;

  hls_exec_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .loop_start(loop_start), .loop_done(loop_done),
    .mod_busy(mod_busy), .mod_txn_cnt(mod_txn_cnt), .mod_last_lat(mod_last_lat),
    .mod_last_ii(mod_last_ii), .loop_active(loop_active), .loop_invoc_cnt(loop_invoc_cnt),
    .loop_iter_cnt(loop_iter_cnt), .loop_last_trip(loop_last_trip),
    .loop_stall_cnt(loop_stall_cnt), .frozen(frozen)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   CNT_W'(mod_busy), 0);
    chk({tag, "_txn"},    mod_txn_cnt, 0);
    chk({tag, "_lat"},    mod_last_lat, 0);
    chk({tag, "_ii"},     mod_last_ii, 0);
    chk({tag, "_lact"},   CNT_W'(loop_active), 0);
    chk({tag, "_invoc"},  loop_invoc_cnt, 0);
    chk({tag, "_iter"},   loop_iter_cnt, 0);
    chk({tag, "_trip"},   loop_last_trip, 0);
    chk({tag, "_stall"},  loop_stall_cnt, 0);
    chk({tag, "_frozen"}, CNT_W'(frozen), 0);
  endtask

  initial begin
    st_idle = '0; st_idle[0] = 1'b1;
    st_a    = '0; st_a[3]    = 1'b1;
    st_b    = '0; st_b[5]    = 1'b1;
    st_p    = '0; st_p[7]    = 1'b1;
    reset = 1'b0; finish = 1'b0; ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
    ap_continue = 1'b1; cur_state = st_idle; iter_start_state = st_a; iter_end_state = st_b;
    iter_start_block = 1'b0; iter_end_block = 1'b0;
    iter_start_enable = 1'b1; iter_end_enable = 1'b1; loop_start = 1'b0; loop_done = 1'b0;
    step(); step();
    chk_all_zero("rst");
    reset = 1'b1;
    step();

    // single transaction, latency 5
    ap_start = 1'b1; step(); ap_start = 1'b0;
    chk("a_busy", CNT_W'(mod_busy), 1);
    chk("a_ii0", mod_last_ii, 0);
    repeat (4) step();
    ap_done = 1'b1; step(); ap_done = 1'b0;
    chk("a_txn", mod_txn_cnt, 1);
    chk("a_lat", mod_last_lat, 5);
    chk("a_idle", CNT_W'(mod_busy), 0);

    // back-to-back: start, done+start 5 later, done 7 later
    ap_start = 1'b1; step(); ap_start = 1'b0;
    chk("b_ii6", mod_last_ii, 6);
    repeat (4) step();
    ap_done = 1'b1; ap_start = 1'b1; step(); ap_done = 1'b0; ap_start = 1'b0;
    chk("b_txn2", mod_txn_cnt, 2);
    chk("b_lat5", mod_last_lat, 5);
    chk("b_ii5", mod_last_ii, 5);
    chk("b_busy", CNT_W'(mod_busy), 1);
    repeat (6) step();
    ap_done = 1'b1; step(); ap_done = 1'b0;
    chk("b_txn3", mod_txn_cnt, 3);
    chk("b_lat7", mod_last_lat, 7);
    chk("b_ii_hold", mod_last_ii, 5);
    chk("b_idle", CNT_W'(mod_busy), 0);

    // ap_continue low holds RUN while latency keeps counting
    ap_start = 1'b1; step(); ap_start = 1'b0;
    chk("c_ii8", mod_last_ii, 8);
    step();
    ap_done = 1'b1; ap_continue = 1'b0; step(); step();
    chk("c_hold_busy", CNT_W'(mod_busy), 1);
    chk("c_hold_txn", mod_txn_cnt, 3);
    ap_continue = 1'b1; step(); ap_done = 1'b0;
    chk("c_lat4", mod_last_lat, 4);
    chk("c_txn4", mod_txn_cnt, 4);

    // stray done in IDLE ignored; start+done together in IDLE gives latency 0
    ap_done = 1'b1; step(); ap_done = 1'b0;
    chk("d_txn", mod_txn_cnt, 4);
    chk("d_busy", CNT_W'(mod_busy), 0);
    ap_start = 1'b1; ap_done = 1'b1; step(); ap_start = 1'b0; ap_done = 1'b0;
    chk("e_txn5", mod_txn_cnt, 5);
    chk("e_lat0", mod_last_lat, 0);
    chk("e_ii6", mod_last_ii, 6);
    chk("e_busy", CNT_W'(mod_busy), 0);

    // sequential loop: 5 iterations, one end stalled 3 cycles
    loop_start = 1'b1; step(); loop_start = 1'b0;
    chk("l_act", CNT_W'(loop_active), 1);
    chk("l_invoc1", loop_invoc_cnt, 1);
    cur_state = st_b; step();
    cur_state = st_a; step();
    cur_state = st_b; step();
    iter_end_block = 1'b1; repeat (3) step();
    chk("l_stall3", loop_stall_cnt, 3);
    chk("l_iter2", loop_iter_cnt, 2);
    iter_end_block = 1'b0; step();
    cur_state = st_a; step();
    cur_state = st_b; step();
    chk("l_iter4", loop_iter_cnt, 4);
    loop_done = 1'b1; step(); loop_done = 1'b0;
    chk("l_trip5", loop_last_trip, 5);
    chk("l_inact", CNT_W'(loop_active), 0);
    step();
    chk("l_idle_end", loop_iter_cnt, 5);
    chk("l_stall_keep", loop_stall_cnt, 3);
    cur_state = st_idle;

    // pipelined loop: start and end states equal
    iter_start_state = st_p; iter_end_state = st_p;
    loop_start = 1'b1; step(); loop_start = 1'b0;
    chk("p_invoc2", loop_invoc_cnt, 2);
    chk("p_iter0", loop_iter_cnt, 0);
    cur_state = st_p; iter_start_enable = 1'b0; iter_end_enable = 1'b0; iter_end_block = 1'b1;
    step();
    chk("p_noen_iter", loop_iter_cnt, 0);
    chk("p_noen_stall", loop_stall_cnt, 3);
    iter_end_block = 1'b0; iter_start_enable = 1'b1; iter_end_enable = 1'b1;
    repeat (3) step();
    chk("p_iter3", loop_iter_cnt, 3);
    iter_start_block = 1'b1; iter_end_block = 1'b1; step();
    iter_start_block = 1'b0; iter_end_block = 1'b0;
    chk("p_stall_once", loop_stall_cnt, 4);
    chk("p_iter_blk", loop_iter_cnt, 3);
    loop_done = 1'b1; loop_start = 1'b1; step(); loop_start = 1'b0;
    chk("p_trip4", loop_last_trip, 4);
    chk("p_restart_iter", loop_iter_cnt, 0);
    chk("p_invoc3", loop_invoc_cnt, 3);
    chk("p_restart_act", CNT_W'(loop_active), 1);
    cur_state = st_idle; step(); loop_done = 1'b0;
    chk("p_trip0", loop_last_trip, 0);
    chk("p_inact", CNT_W'(loop_active), 0);

    // finish freezes everything
    finish = 1'b1; step(); finish = 1'b0;
    chk("f_frozen", CNT_W'(frozen), 1);
    ap_start = 1'b1; step();
    ap_done = 1'b1; loop_start = 1'b1; step();
    ap_start = 1'b0; ap_done = 1'b0; loop_start = 1'b0;
    chk("f_txn", mod_txn_cnt, 5);
    chk("f_busy", CNT_W'(mod_busy), 0);
    chk("f_ii", mod_last_ii, 6);
    chk("f_invoc", loop_invoc_cnt, 3);
    chk("f_still", CNT_W'(frozen), 1);

    // reset clears freeze, then reset asserted mid-transaction
    reset = 1'b0; step(); reset = 1'b1; step();
    chk("r_unfrozen", CNT_W'(frozen), 0);
    ap_start = 1'b1; step(); ap_start = 1'b0;
    chk("r_busy", CNT_W'(mod_busy), 1);
    step();
    reset = 1'b0; step();
    chk_all_zero("rmid");
    reset = 1'b1; step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
